rf_op_sequencer: RTL and testbench

- Initiator-side controller that drives the register file's two read ports and its write port.
- Accepts one register-transfer command at a time over a valid/ready handshake and reads source operands.
- Computes an 8-bit ALU result and writes it back, or returns the read value on a response handshake.
- Sits between the instruction decode/control path and the register file, as its sole port driver.

---
 rtl/rf_seq_pkg.sv | 24 ++
 rtl/rf_seq_alu.sv | 36 +++
 rtl/rf_op_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_rf_op_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_seq_pkg.sv
// Shared opcodes, FSM state encodings and default widths for the register-file op sequencer.
package rf_seq_pkg;

    localparam int RF_DATA_W = 8;
    localparam int RF_ADDR_W = 4;

    typedef logic [2:0] op_t;

    localparam op_t OP_MOV = 3'b000;
    localparam op_t OP_ADD = 3'b001;
    localparam op_t OP_SUB = 3'b010;
    localparam op_t OP_AND = 3'b011;
    localparam op_t OP_OR  = 3'b100;
    localparam op_t OP_XOR = 3'b101;
    localparam op_t OP_LDI = 3'b110;
    localparam op_t OP_RD  = 3'b111;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_EXEC  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_RESP  = 3'd4;

endpackage

// File: rtl/rf_seq_alu.sv
// Combinational ALU for the op sequencer: result plus carry (ADD) or borrow (SUB).
module rf_seq_alu
    import rf_seq_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W
) (
    input  op_t               op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] result_o,
    output logic              carry_o
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    // The extra top bit is the carry-out for ADD and the borrow (a < b) for SUB.
    assign sum  = {1'b0, a_i} + {1'b0, b_i};
    assign diff = {1'b0, a_i} - {1'b0, b_i};

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        result_o = a_i;
        carry_o  = 1'b0;
        case (op_i)
            OP_MOV: result_o = a_i;
            OP_ADD: {carry_o, result_o} = sum;
            OP_SUB: {carry_o, result_o} = diff;
            OP_AND: result_o = a_i & b_i;
            OP_OR:  result_o = a_i | b_i;
            OP_XOR: result_o = a_i ^ b_i;
            default: result_o = a_i;
        endcase
    end

endmodule

// File: rtl/rf_op_sequencer.sv
// Register-file op sequencer: one command at a time, IDLE->READ->EXEC->WRITE, IDLE->WRITE (LDI),
// or IDLE->READ->RESP (RD). Zero/carry status flags are built only when RF_SEQ_FLAGS_EN is defined.
module rf_op_sequencer
    import rf_seq_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  op_t               cmd_op,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [ADDR_W-1:0] cmd_src1,
    input  logic [ADDR_W-1:0] cmd_src2,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] rf_read_addr1,
    output logic [ADDR_W-1:0] rf_read_addr2,
    input  logic [DATA_W-1:0] rf_read_data1,
    input  logic [DATA_W-1:0] rf_read_data2,
    output logic [ADDR_W-1:0] rf_write_addr,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              rf_write_enable
`ifdef RF_SEQ_FLAGS_EN
    ,
    output logic              flag_z,
    output logic              flag_c
`endif
);

    logic [2:0]        state_q,     state_d;
    op_t               op_q,        op_d;
    logic [ADDR_W-1:0] dst_q,       dst_d;
    logic [DATA_W-1:0] op1_q,       op1_d;
    logic [DATA_W-1:0] op2_q,       op2_d;
    logic [ADDR_W-1:0] raddr1_q,    raddr1_d;
    logic [ADDR_W-1:0] raddr2_q,    raddr2_d;
    logic [ADDR_W-1:0] waddr_q,     waddr_d;
    logic [DATA_W-1:0] wdata_q,     wdata_d;
    logic              we_q,        we_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;

    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;

    rf_seq_alu #(.DATA_W(DATA_W)) u_alu (
        .op_i     (op_q),
        .a_i      (op1_q),
        .b_i      (op2_q),
        .result_o (alu_result),
        .carry_o  (alu_carry)
    );

`ifdef RF_SEQ_FLAGS_EN
    logic flag_z_q, flag_z_d;
    logic flag_c_q, flag_c_d;
`else
    logic unused_carry;
    assign unused_carry = alu_carry;
`endif

    // Gated by reset so nothing is accepted while the block is held in reset.
    assign cmd_ready = (state_q == ST_IDLE) & reset;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        dst_d       = dst_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        raddr1_d    = raddr1_q;
        raddr2_d    = raddr2_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        we_d        = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
`ifdef RF_SEQ_FLAGS_EN
        flag_z_d    = flag_z_q;
        flag_c_d    = flag_c_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_d     = cmd_op;
                    dst_d    = cmd_dst;
                    raddr1_d = cmd_src1;
                    raddr2_d = cmd_src2;
                    if (cmd_op == OP_LDI) begin
                        we_d    = 1'b1;
                        waddr_d = cmd_dst;
                        wdata_d = cmd_imm;
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                op1_d = rf_read_data1;
                op2_d = rf_read_data2;
                if (op_q == OP_RD) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = rf_read_data1;
                    state_d     = ST_RESP;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                we_d    = 1'b1;
                waddr_d = dst_q;
                wdata_d = alu_result;
`ifdef RF_SEQ_FLAGS_EN
                flag_z_d = (alu_result == '0);
                flag_c_d = alu_carry;
`endif
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_MOV;
            dst_q       <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            raddr1_q    <= '0;
            raddr2_q    <= '0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
`ifdef RF_SEQ_FLAGS_EN
            flag_z_q    <= 1'b0;
            flag_c_q    <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values together.
            state_q     <= state_d;
            op_q        <= op_d;
            dst_q       <= dst_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            raddr1_q    <= raddr1_d;
            raddr2_q    <= raddr2_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
`ifdef RF_SEQ_FLAGS_EN
            flag_z_q    <= flag_z_d;
            flag_c_q    <= flag_c_d;
`endif
        end
    end

    assign rsp_valid       = rsp_valid_q;
    assign rsp_data        = rsp_data_q;
    assign rf_read_addr1   = raddr1_q;
    assign rf_read_addr2   = raddr2_q;
    assign rf_write_addr   = waddr_q;
    assign rf_write_data   = wdata_q;
    assign rf_write_enable = we_q;
`ifdef RF_SEQ_FLAGS_EN
    assign flag_z          = flag_z_q;
    assign flag_c          = flag_c_q;
`endif

endmodule

// File: tb/tb_rf_op_sequencer.sv
// Self-checking bench for rf_op_sequencer: table-driven commands against a register-file model,
// write/response scoreboards, plus busy, backpressure and reset-abort sequences.
module tb_rf_op_sequencer;
    import rf_seq_pkg::*;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    op_t           cmd_op;
    logic [AW-1:0] cmd_dst;
    logic [AW-1:0] cmd_src1;
    logic [AW-1:0] cmd_src2;
    logic [DW-1:0] cmd_imm;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] rf_read_addr1;
    logic [AW-1:0] rf_read_addr2;
    logic [DW-1:0] rf_read_data1;
    logic [DW-1:0] rf_read_data2;
    logic [AW-1:0] rf_write_addr;
    logic [DW-1:0] rf_write_data;
    logic          rf_write_enable;
`ifdef RF_SEQ_FLAGS_EN
    logic          flag_z;
    logic          flag_c;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        op_t           op;
        logic [AW-1:0] dst;
        logic [AW-1:0] s1;
        logic [AW-1:0] s2;
        logic [DW-1:0] imm;
        logic [DW-1:0] exp_data;
        int            exp_lat;
        logic          exp_z;
        logic          exp_c;
    } vec_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_exp_t;

    vec_t          vecs [15];
    wr_exp_t       wr_q [$];
    logic [DW-1:0] rsp_q [$];
    wr_exp_t       wr_e;
    logic [DW-1:0] rsp_e;
    logic          rsp_prev = 1'b0;

    logic [DW-1:0] rf [16] = '{default: '0};

    rf_op_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_op          (cmd_op),
        .cmd_dst         (cmd_dst),
        .cmd_src1        (cmd_src1),
        .cmd_src2        (cmd_src2),
        .cmd_imm         (cmd_imm),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_data        (rsp_data),
        .rf_read_addr1   (rf_read_addr1),
        .rf_read_addr2   (rf_read_addr2),
        .rf_read_data1   (rf_read_data1),
        .rf_read_data2   (rf_read_data2),
        .rf_write_addr   (rf_write_addr),
        .rf_write_data   (rf_write_data),
        .rf_write_enable (rf_write_enable)
`ifdef RF_SEQ_FLAGS_EN
        ,
        .flag_z          (flag_z),
        .flag_c          (flag_c)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: combinational reads, write at the clock edge.
    assign rf_read_data1 = rf[rf_read_addr1];
    assign rf_read_data2 = rf[rf_read_addr2];
    always @(posedge clk) begin
        if (rf_write_enable) rf[rf_write_addr] <= rf_write_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Write scoreboard: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (rf_write_enable) begin
            if (wr_q.size() == 0) begin
                check("spurious_write", 32'(rf_write_enable), 32'd0);
            end else begin
                wr_e = wr_q.pop_front();
                check("wr_addr", 32'(rf_write_addr), 32'(wr_e.addr));
                check("wr_data", 32'(rf_write_data), 32'(wr_e.data));
            end
        end
    end

    // Response scoreboard: compared when rsp_valid rises.
    always @(negedge clk) begin
        if (rsp_valid && !rsp_prev) begin
            if (rsp_q.size() == 0) begin
                check("spurious_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                rsp_e = rsp_q.pop_front();
                check("rsp_data", 32'(rsp_data), 32'(rsp_e));
            end
        end
        rsp_prev = rsp_valid;
    end

    task automatic wait_ready();
        int n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    endtask

    task automatic drive_cmd(input op_t op, input logic [AW-1:0] dst, input logic [AW-1:0] s1,
                             input logic [AW-1:0] s2, input logic [DW-1:0] imm);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_dst   = dst;
        cmd_src1  = s1;
        cmd_src2  = s2;
        cmd_imm   = imm;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int lat;
        bit seen;
        wait_ready();
        drive_cmd(v.op, v.dst, v.s1, v.s2, v.imm);
        if (v.op == OP_RD) rsp_q.push_back(v.exp_data);
        else               wr_q.push_back('{addr: v.dst, data: v.exp_data});
        @(negedge clk);
        cmd_valid = 1'b0;
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat <= 10) begin
            if ((v.op == OP_RD) ? rsp_valid : rf_write_enable) begin
                seen = 1'b1;
            end else begin
                @(negedge clk);
                lat++;
            end
        end
        check($sformatf("latency[%0d]", idx), 32'(lat), 32'(v.exp_lat));
        if (v.op == OP_RD) begin
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            check($sformatf("rsp_drop[%0d]", idx), 32'(rsp_valid), 32'd0);
        end else begin
            @(negedge clk);
        end
        check($sformatf("ready_after[%0d]", idx), 32'(cmd_ready), 32'd1);
`ifdef RF_SEQ_FLAGS_EN
        check($sformatf("flag_z[%0d]", idx), 32'(flag_z), 32'(v.exp_z));
        check($sformatf("flag_c[%0d]", idx), 32'(flag_c), 32'(v.exp_c));
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        int last;
        int accepts;
        int wcnt;
        logic [DW-1:0] r13_exp;

        //           op      dst    s1     s2     imm    exp    lat z     c
        vecs[0]  = '{OP_LDI, 4'd0,  4'd0,  4'd0,  8'hA5, 8'hA5, 1, 1'b0, 1'b0};
        vecs[1]  = '{OP_LDI, 4'd1,  4'd0,  4'd0,  8'h5A, 8'h5A, 1, 1'b0, 1'b0};
        vecs[2]  = '{OP_ADD, 4'd2,  4'd0,  4'd1,  8'h00, 8'hFF, 3, 1'b0, 1'b0};
        vecs[3]  = '{OP_RD,  4'd0,  4'd2,  4'd0,  8'h00, 8'hFF, 2, 1'b0, 1'b0};
        vecs[4]  = '{OP_SUB, 4'd3,  4'd1,  4'd0,  8'h00, 8'hB5, 3, 1'b0, 1'b1};
        vecs[5]  = '{OP_LDI, 4'd5,  4'd0,  4'd0,  8'h01, 8'h01, 1, 1'b0, 1'b1};
        vecs[6]  = '{OP_ADD, 4'd6,  4'd2,  4'd5,  8'h00, 8'h00, 3, 1'b1, 1'b1};
        vecs[7]  = '{OP_MOV, 4'd8,  4'd3,  4'd0,  8'h00, 8'hB5, 3, 1'b0, 1'b0};
        vecs[8]  = '{OP_AND, 4'd9,  4'd0,  4'd3,  8'h00, 8'hA5, 3, 1'b0, 1'b0};
        vecs[9]  = '{OP_OR,  4'd10, 4'd0,  4'd1,  8'h00, 8'hFF, 3, 1'b0, 1'b0};
        vecs[10] = '{OP_XOR, 4'd11, 4'd0,  4'd0,  8'h00, 8'h00, 3, 1'b1, 1'b0};
        vecs[11] = '{OP_ADD, 4'd1,  4'd1,  4'd1,  8'h00, 8'hB4, 3, 1'b0, 1'b0};
        vecs[12] = '{OP_RD,  4'd0,  4'd1,  4'd0,  8'h00, 8'hB4, 2, 1'b0, 1'b0};
        vecs[13] = '{OP_SUB, 4'd12, 4'd5,  4'd5,  8'h00, 8'h00, 3, 1'b1, 1'b0};
        vecs[14] = '{OP_RD,  4'd0,  4'd11, 4'd0,  8'h00, 8'h00, 2, 1'b1, 1'b0};

        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = OP_MOV;
        cmd_dst   = '0;
        cmd_src1  = '0;
        cmd_src2  = '0;
        cmd_imm   = '0;
        rsp_ready = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_we",        32'(rf_write_enable), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data",  32'(rsp_data), 32'd0);
        check("rst_raddr1",    32'(rf_read_addr1), 32'd0);
        check("rst_wdata",     32'(rf_write_data), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

        // Busy handshake: valid held high, ADD r13 = r13 + r5 accepted every 4 cycles.
        wait_ready();
        drive_cmd(OP_ADD, 4'd13, 4'd13, 4'd5, 8'h00);
        last    = -1;
        accepts = 0;
        wcnt    = 0;
        r13_exp = 8'h00;
        for (int c = 0; c < 12; c++) begin
            if (cmd_ready) begin
                accepts++;
                if (last >= 0) check("accept_spacing", 32'(c - last), 32'd4);
                last = c;
                r13_exp = r13_exp + 8'h01;
                wr_q.push_back('{addr: 4'd13, data: r13_exp});
            end
            if (rf_write_enable) wcnt++;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        check("busy_accepts", 32'(accepts), 32'd3);
        check("busy_writes",  32'(wcnt), 32'd3);

        // Response backpressure: RD r3 held for 5 cycles.
        wait_ready();
        drive_cmd(OP_RD, 4'd0, 4'd3, 4'd0, 8'h00);
        rsp_q.push_back(8'hB5);
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        wcnt = 0;
        for (int c = 0; c < 5; c++) begin
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_data",  32'(rsp_data), 32'hB5);
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            if (rf_write_enable) wcnt++;
            @(negedge clk);
        end
        check("bp_no_write", 32'(wcnt), 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("bp_rsp_drop",  32'(rsp_valid), 32'd0);
        check("bp_idle_ready", 32'(cmd_ready), 32'd1);

        // Reset during READ of ADD r7.
        wait_ready();
        drive_cmd(OP_ADD, 4'd7, 4'd0, 4'd1, 8'h00);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("abort_rd_we",    32'(rf_write_enable), 32'd0);
        check("abort_rd_ready", 32'(cmd_ready), 32'd0);
        check("abort_rd_wdata", 32'(rf_write_data), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_rd_release_ready", 32'(cmd_ready), 32'd1);
        check("abort_rd_r7", 32'(rf[7]), 32'd0);

        // Reset during WRITE of ADD r7: the strobe must drop without waiting for a clock.
        wait_ready();
        drive_cmd(OP_ADD, 4'd7, 4'd0, 4'd1, 8'h00);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("abort_wr_we_high", 32'(rf_write_enable), 32'd1);
        #1 reset = 1'b0;
        #1;
        check("abort_wr_we_drop", 32'(rf_write_enable), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_wr_r7", 32'(rf[7]), 32'd0);
        check("abort_wr_ready", 32'(cmd_ready), 32'd1);
`ifdef RF_SEQ_FLAGS_EN
        check("abort_flag_z", 32'(flag_z), 32'd0);
        check("abort_flag_c", 32'(flag_c), 32'd0);
`endif

        @(negedge clk);
        check("wr_q_drained",  32'(wr_q.size()), 32'd0);
        check("rsp_q_drained", 32'(rsp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
